// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - opcodes, sequencer states and opcode classes for datapath_seq
package datapath_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;

   typedef enum logic [2:0] {
      IDLE, S_Y, S_Z, S_ITER, S_MAR, S_MEM, S_WB, S_DONE
   } state_t;

   function automatic logic is_alu(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
         OP_AND, OP_OR, OP_NEG, OP_NOT: is_alu = 1'b1;
         default:                       is_alu = 1'b0;
      endcase
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      is_muldiv = (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/datapath_seq_muldiv.sv
// rtl/datapath_seq_muldiv.sv - iterative unsigned shift-add multiply and restoring divide, one bit per cycle
module seq_muldiv
   import datapath_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_op;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;

   always_comb begin
      w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_sh   = {r_hi, r_lo[WIDTH-1]};
      w_diff = w_sh - {1'b0, r_b};
      w_ge   = (w_sh >= {1'b0, r_b});
   end

   // Divide by zero needs no special case: every trial subtract succeeds,
   // so the quotient fills with ones and the dividend shifts into the remainder.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_b   <= '0;
         r_cnt <= '0;
         r_op  <= 1'b0;
      end else if (start) begin
         r_hi  <= '0;
         r_lo  <= a;
         r_b   <= b;
         r_op  <= op;
         r_cnt <= CW'(WIDTH);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
         if (!r_op) begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
         end else if (w_ge) begin
            r_hi <= w_diff[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
         end else begin
            r_hi <= w_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = (r_cnt != '0);

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - register-file datapath with a micro-sequencer executing one command per handshake
module datapath_seq
   import datapath_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int NREGS = 16,
   localparam int RAW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [4:0]       cmd_op,
   input  logic [RAW-1:0]   cmd_ra,
   input  logic [RAW-1:0]   cmd_rb,
   input  logic [RAW-1:0]   cmd_rc,
   output logic             done,
   output logic             err,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [WIDTH-1:0] bus_dbg,
   input  logic [RAW-1:0]   dbg_addr,
   output logic [WIDTH-1:0] dbg_data,
   output logic [WIDTH-1:0] hi_dbg,
   output logic [WIDTH-1:0] lo_dbg
);

   localparam int SW = $clog2(WIDTH);

   state_t           r_state;
   logic [4:0]       r_op;
   logic [RAW-1:0]   r_ra;
   logic [RAW-1:0]   r_rb;
   logic [RAW-1:0]   r_rc;
   logic [WIDTH-1:0] r_regs [NREGS];
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_zlo;
   logic [WIDTH-1:0] r_mar;
   logic [WIDTH-1:0] r_mdr;
   logic [SW-1:0]    r_iter;
   logic             r_done;
   logic             r_err;
   logic             r_mem_req;
   logic             r_cmd_ready;

   logic [WIDTH-1:0] w_bus;
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_lo;
   logic             w_busy;
   logic             w_start;

   function automatic logic [WIDTH-1:0] alu(input logic [4:0] op,
                                            input logic [WIDTH-1:0] y,
                                            input logic [WIDTH-1:0] b);
      logic [SW-1:0] n;
      n = b[SW-1:0];
      case (op)
         OP_ADD:  alu = y + b;
         OP_SUB:  alu = y - b;
         OP_AND:  alu = y & b;
         OP_OR:   alu = y | b;
         OP_SHR:  alu = y >> n;
         OP_SHL:  alu = y << n;
         // A zero amount shifts the wrapped half by WIDTH, which yields 0.
         OP_ROR:  alu = (y >> n) | (y << (WIDTH - int'(n)));
         OP_ROL:  alu = (y << n) | (y >> (WIDTH - int'(n)));
         OP_NEG:  alu = -y;
         OP_NOT:  alu = ~y;
         default: alu = '0;
      endcase
   endfunction

   always_comb begin
      w_bus = '0;
      case (r_state)
         S_Y, S_MAR: w_bus = r_regs[r_rb];
         S_Z:        w_bus = r_regs[r_rc];
         S_WB: begin
            case (r_op)
               OP_LD:   w_bus = r_mdr;
               OP_MFHI: w_bus = w_hi;
               OP_MFLO: w_bus = w_lo;
               default: w_bus = r_zlo;
            endcase
         end
         default:    w_bus = '0;
      endcase
   end

   assign w_start = (r_state == S_Z) && is_muldiv(r_op);

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk   (clk),
      .clr   (clr),
      .start (w_start),
      .op    (r_op == OP_DIV),
      .a     (r_y),
      .b     (w_bus),
      .hi    (w_hi),
      .lo    (w_lo),
      .busy  (w_busy)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state     <= IDLE;
         r_op        <= '0;
         r_ra        <= '0;
         r_rb        <= '0;
         r_rc        <= '0;
         r_y         <= '0;
         r_zlo       <= '0;
         r_mar       <= '0;
         r_mdr       <= '0;
         r_iter      <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_mem_req   <= 1'b0;
         r_cmd_ready <= 1'b1;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_op        <= cmd_op;
                  r_ra        <= cmd_ra;
                  r_rb        <= cmd_rb;
                  r_rc        <= cmd_rc;
                  r_cmd_ready <= 1'b0;
                  if (is_alu(cmd_op) || is_muldiv(cmd_op)) begin
                     r_state <= S_Y;
                  end else if (cmd_op == OP_LD) begin
                     r_state <= S_MAR;
                  end else if (cmd_op == OP_MFHI || cmd_op == OP_MFLO) begin
                     r_state <= S_WB;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_Y: begin
               r_y     <= w_bus;
               r_state <= S_Z;
            end
            S_Z: begin
               if (is_muldiv(r_op)) begin
                  r_iter  <= SW'(WIDTH - 1);
                  r_state <= S_ITER;
               end else begin
                  r_zlo   <= alu(r_op, r_y, w_bus);
                  r_state <= S_WB;
               end
            end
            S_ITER: begin
               if (r_iter == '0 || !w_busy) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_iter <= r_iter - 1'b1;
               end
            end
            S_MAR: begin
               r_mar     <= w_bus;
               r_mem_req <= 1'b1;
               r_state   <= S_MEM;
            end
            S_MEM: begin
               if (mem_ack) begin
                  r_mdr     <= mem_rdata;
                  r_mem_req <= 1'b0;
                  r_state   <= S_WB;
               end
            end
            S_WB: begin
               r_regs[r_ra] <= w_bus;
               r_state      <= S_DONE;
               r_done       <= 1'b1;
            end
            S_DONE: begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign done      = r_done;
   assign err       = r_err;
   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mar;
   assign bus_dbg   = w_bus;
   assign dbg_data  = r_regs[dbg_addr];
   assign hi_dbg    = w_hi;
   assign lo_dbg    = w_lo;

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised successor to the phase-1 datapath.
- WIDTH-bit internal bus, NREGS-entry register file, Y, ZHI/ZLO, HI, LO, MAR and MDR.
- Built-in micro-sequencer that executes one register-level command per handshake, replacing testbench-driven control strobes.
- Adds iterative MUL/DIV into HI/LO, memory load through an MDR request/ack handshake, and MFHI/MFLO moves.

Parameters:
- WIDTH, 32, data/bus width in bits (power of 2, >=8).
- NREGS, 16, number of general registers (power of 2).
- RAW, $clog2(NREGS), register address width (derived; not to be overridden).

Ports:
- clk  in  1  single clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle, can accept a command.
- cmd_op  in  5  opcode, encodings listed under Decomposition.
- cmd_ra  in  RAW  destination register.
- cmd_rb  in  RAW  source A, or address register for LD.
- cmd_rc  in  RAW  source B / shift count register.
- done  out  1  one-cycle pulse when a command retires.
- err  out  1  pulses with done when the opcode is illegal.
- mem_req  out  1  memory read request.
- mem_addr  out  WIDTH  equals MAR.
- mem_ack  in  1  read data valid.
- mem_rdata  in  WIDTH  read data.
- bus_dbg  out  WIDTH  current internal bus value.
- dbg_addr  in  RAW  register-file observe address.
- dbg_data  out  WIDTH  combinational R[dbg_addr].
- hi_dbg  out  WIDTH  HI register.
- lo_dbg  out  WIDTH  LO register.

Behaviour:
- Reset (clr=0, any time, asynchronous):
  - All registers, Y, Z, HI, LO, MAR, MDR cleared to 0; state goes to IDLE.
  - Outputs: cmd_ready=1, done=0, err=0, mem_req=0.
  - An in-flight command is abandoned with no writes.
- Accept: on a rising edge with cmd_valid && cmd_ready.
  - Fields are latched; cmd_ready=0 until the cycle after done.
- ALU ops (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT), one state per cycle:
  - S_Y: bus=R[rb]; Y<=bus.
  - S_Z: bus=R[rc]; ZLO<=f(Y,bus).
  - S_WB: bus=ZLO; R[ra]<=bus.
  - S_DONE: done=1.
  - done rises 4 cycles after the accept edge.
- ALU arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Shift/rotate amount = bus[$clog2(WIDTH)-1:0].
  - SHR is logical.
  - NEG and NOT ignore rc and use Y only.
- MUL/DIV:
  - S_Y, then S_Z loads the operands, then S_ITER runs exactly WIDTH cycles (one bit per cycle), then S_DONE.
  - MUL: unsigned; HI:LO <= Y*R[rc].
  - DIV: unsigned restoring; LO=quotient, HI=remainder.
  - Divide by zero: LO=all ones, HI=Y, err=0.
  - R[ra] is not written; done rises WIDTH+3 cycles after accept.
- LD:
  - S_MAR: bus=R[rb]; MAR<=bus.
  - S_MEM: mem_req=1, held until mem_ack is sampled high; MDR<=mem_rdata on that edge. mem_ack outside S_MEM is ignored.
  - S_WB: bus=MDR; R[ra]<=MDR.
  - S_DONE.
  - With ack on the first S_MEM cycle, done rises 4 cycles after accept. No timeout.
- MFHI/MFLO: S_WB with bus=HI or LO, then S_DONE; done rises 2 cycles after accept.
- Illegal opcode: go directly to S_DONE with err=1; no state changes.
- ra==rb or ra==rc: sources are read in earlier states, so writeback uses the old values.
- Bus when no state drives it: 0.

Decomposition:
- Shared package datapath_pkg holds:
  - Opcode constants: LD=00000, ADD=00011, SUB=00100, SHR=00101, SHL=00110, ROR=00111, ROL=01000, AND=01001, OR=01010, MUL=01110, DIV=01111, NEG=10000, NOT=10001, MFHI=11000, MFLO=11001.
  - State enum: IDLE, S_Y, S_Z, S_ITER, S_MAR, S_MEM, S_WB, S_DONE.
- One sub-module: seq_muldiv.
  - Iterative unsigned multiply/divide with start, op, a, b; outputs hi, lo, busy.
  - Parameterised by WIDTH.
  - Shares the block's clk and clr.

Test Plan:
- Reset mid-LD while mem_req=1, clr low one cycle -> mem_req=0 immediately, cmd_ready=1, dbg_data=0 for all addresses.
- R2=0x0000_0034, R4=0x0000_0045, AND ra=5 rb=2 rc=4 -> done exactly 4 cycles after accept, R5=0x0000_0004; ADD -> R5=0x0000_0079; SUB R4-R2 -> 0x0000_0011.
- R1=0x8000_0001, R3=4, ROR ra=1 rb=1 rc=1-style self-use (rc=3) -> R1=0x1800_0000; SHR -> 0x0800_0000; SHL -> 0x0000_0010.
- MUL R6=0xFFFF_FFFF, R7=2 -> HI=0x0000_0001, LO=0xFFFF_FFFE, done at accept+35 (WIDTH=32); then MFLO ra=8 -> R8=0xFFFF_FFFE.
- DIV 100/7 -> LO=14, HI=2; DIV 5/0 -> LO=0xFFFF_FFFF, HI=5, err=0.
- LD rb=9 (R9=0x40), mem_ack delayed 3 cycles, rdata=0xDEAD_BEEF -> mem_addr=0x40 throughout, R10=0xDEAD_BEEF; opcode 11111 -> done and err together, registers unchanged.
